// File: rtl/product_accumulator.sv
// product_accumulator: sums groups of LEN signed products, optional saturation via PRODUCT_ACCUMULATOR_SAT_EN
module product_accumulator #(
  parameter int P_W   = 64,
  parameter int ACC_W = 72,
  parameter int LEN   = 8,
  parameter int CNT_W = $clog2(LEN + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  input  logic [P_W-1:0]   i_product,
  output logic             o_ready,
  input  logic             i_clear,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [ACC_W-1:0] o_sum,
  output logic [CNT_W-1:0] o_count,
  output logic             o_overflow
);
  typedef enum logic {ACC, DONE} state_t;
  state_t state;
  logic [ACC_W-1:0] acc, addend, nxt;
  logic take;
  assign addend  = ACC_W'($signed(i_product));
  assign o_ready = (state == ACC) && !i_clear;
  assign take    = i_valid && o_ready;
`ifdef PRODUCT_ACCUMULATOR_SAT_EN
  logic [ACC_W-1:0] raw;
  logic ovf_add, hs;
  assign raw     = acc + addend;
  assign ovf_add = (acc[ACC_W-1] == addend[ACC_W-1]) && (raw[ACC_W-1] != acc[ACC_W-1]);
  assign nxt     = !ovf_add ? raw :
                   acc[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
  assign hs      = o_valid && i_ready;
  // sticky per-group saturation flag, dropped on handshake, clear or reset
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear || hs) o_overflow <= 1'b0;
    else if (take && ovf_add) o_overflow <= 1'b1;
  end
`else
  assign nxt        = acc + addend;
  assign o_overflow = 1'b0;
`endif
  // group accumulation and output handshake: rst > clear > handshake > accept
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= ACC;
      acc     <= '0;
      o_count <= '0;
      o_sum   <= '0;
      o_valid <= 1'b0;
    end else if (i_clear) begin
      state   <= ACC;
      acc     <= '0;
      o_count <= '0;
      o_valid <= 1'b0;
    end else if (state == DONE) begin
      if (i_ready) begin
        state   <= ACC;
        o_valid <= 1'b0;
        o_count <= '0;
      end
    end else if (take) begin
      if (o_count == CNT_W'(LEN - 1)) begin
        o_sum   <= nxt;
        o_valid <= 1'b1;
        state   <= DONE;
        acc     <= '0;
        o_count <= CNT_W'(LEN);
      end else begin
        acc     <= nxt;
        o_count <= o_count + CNT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_product_accumulator.sv
// tb_product_accumulator: scoreboard bench for product_accumulator (LEN=4/72b, LEN=4/64b, LEN=1)
module tb_product_accumulator;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1, clr = 1'b0;
  logic [63:0] prod = '0;
  logic a_v = 1'b0, a_rdy = 1'b1, b_v = 1'b0, b_rdy = 1'b1, c_v = 1'b0, c_rdy = 1'b1;
  logic a_or, a_ov, a_ovf, b_or, b_ov, b_ovf, c_or, c_ov, c_ovf;
  logic [71:0] a_sum, c_sum;
  logic [63:0] b_sum;
  logic [2:0] a_cnt, b_cnt;
  logic [0:0] c_cnt;
  int total = 0, bad = 0;
  logic [71:0] sb[$];
`ifdef PRODUCT_ACCUMULATOR_SAT_EN
  localparam logic [71:0] B_SUM = 72'h00_7FFF_FFFF_FFFF_FFFF;
  localparam logic [71:0] B_OV  = 72'd1;
`else
  localparam logic [71:0] B_SUM = 72'd0;
  localparam logic [71:0] B_OV  = 72'd0;
`endif
  product_accumulator #(.P_W(64), .ACC_W(72), .LEN(4)) u_a (
    .i_clk(clk), .i_rst(rst), .i_valid(a_v), .i_product(prod), .o_ready(a_or),
    .i_clear(clr), .o_valid(a_ov), .i_ready(a_rdy), .o_sum(a_sum), .o_count(a_cnt),
    .o_overflow(a_ovf));
  product_accumulator #(.P_W(64), .ACC_W(64), .LEN(4)) u_b (
    .i_clk(clk), .i_rst(rst), .i_valid(b_v), .i_product(prod), .o_ready(b_or),
    .i_clear(1'b0), .o_valid(b_ov), .i_ready(b_rdy), .o_sum(b_sum), .o_count(b_cnt),
    .o_overflow(b_ovf));
  product_accumulator #(.P_W(64), .ACC_W(72), .LEN(1)) u_c (
    .i_clk(clk), .i_rst(rst), .i_valid(c_v), .i_product(prod), .o_ready(c_or),
    .i_clear(1'b0), .o_valid(c_ov), .i_ready(c_rdy), .o_sum(c_sum), .o_count(c_cnt),
    .o_overflow(c_ovf));
  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [71:0] sx(input logic [63:0] p);
    return {{8{p[63]}}, p};
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic feed_a(input logic [63:0] p);
    a_v = 1'b1;
    prod = p;
    step();
    a_v = 1'b0;
  endtask
  task automatic group_a(input logic [63:0] p0, p1, p2, p3, input bit push);
    if (push) sb.push_back(sx(p0) + sx(p1) + sx(p2) + sx(p3));
    feed_a(p0);
    feed_a(p1);
    feed_a(p2);
    feed_a(p3);
    check("lat_valid", 72'(a_ov), 72'd1);
    check("done_cnt", 72'(a_cnt), 72'd4);
    check("done_rdy", 72'(a_or), 72'd0);
    if (a_rdy) begin
      step();
      check("post_valid", 72'(a_ov), 72'd0);
      check("post_rdy", 72'(a_or), 72'd1);
      check("post_cnt", 72'(a_cnt), 72'd0);
    end
  endtask
  // scoreboard: pop and compare on every completed output handshake
  always @(negedge clk) begin
    if (!rst && a_ov && a_rdy) begin
      if (sb.size() == 0) check("sb_unexp", 72'(sb.size()), 72'd1);
      else begin
        check("sb_sum", a_sum, sb.pop_front());
        check("sb_cnt", 72'(a_cnt), 72'd4);
        check("sb_ovf", 72'(a_ovf), 72'd0);
      end
    end
  end
  initial begin
    step();
    step();
    rst = 1'b0;
    check("rst_valid", 72'(a_ov), 72'd0);
    check("rst_sum", a_sum, 72'd0);
    check("rst_cnt", 72'(a_cnt), 72'd0);
    check("rst_rdy", 72'(a_or), 72'd1);
    check("rst_ovf", 72'(a_ovf), 72'd0);
    group_a(64'd1, 64'd2, 64'd3, 64'd4, 1'b1);
    group_a(-64'sd5, 64'd3, 64'd0, -64'sd1, 1'b1);
    a_rdy = 1'b0;
    sb.push_back(72'd28);
    group_a(64'd7, 64'd7, 64'd7, 64'd7, 1'b0);
    a_v = 1'b1;
    prod = 64'd99;
    repeat (5) begin
      step();
      check("bp_valid", 72'(a_ov), 72'd1);
      check("bp_sum", a_sum, 72'd28);
      check("bp_rdy", 72'(a_or), 72'd0);
      check("bp_cnt", 72'(a_cnt), 72'd4);
    end
    a_v = 1'b0;
    a_rdy = 1'b1;
    step();
    check("bp_release", 72'(a_ov), 72'd0);
    group_a(64'd1, 64'd2, 64'd3, 64'd4, 1'b1);
    feed_a(64'd5);
    feed_a(64'd5);
    check("clr_cnt2", 72'(a_cnt), 72'd2);
    clr = 1'b1;
    a_v = 1'b1;
    prod = 64'd100;
    #1;
    check("clr_rdy", 72'(a_or), 72'd0);
    step();
    clr = 1'b0;
    a_v = 1'b0;
    check("clr_cnt", 72'(a_cnt), 72'd0);
    check("clr_valid", 72'(a_ov), 72'd0);
    check("clr_sum_kept", a_sum, 72'd10);
    group_a(64'd10, 64'd10, 64'd10, 64'd10, 1'b1);
    a_rdy = 1'b0;
    group_a(64'd1, 64'd2, 64'd3, 64'd4, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rd_valid", 72'(a_ov), 72'd0);
    check("rd_sum", a_sum, 72'd0);
    check("rd_cnt", 72'(a_cnt), 72'd0);
    check("rd_rdy", 72'(a_or), 72'd1);
    a_rdy = 1'b1;
    group_a(64'd1, 64'd1, 64'd1, 64'd1, 1'b1);
    prod = 64'h4000_0000_0000_0000;
    b_v = 1'b1;
    step();
    step();
    check("b_ovf_mid", 72'(b_ovf), B_OV);
    step();
    step();
    b_v = 1'b0;
    check("b_valid", 72'(b_ov), 72'd1);
    check("b_sum", 72'(b_sum), B_SUM);
    check("b_ovf", 72'(b_ovf), B_OV);
    check("b_cnt", 72'(b_cnt), 72'd4);
    step();
    check("b_hs_valid", 72'(b_ov), 72'd0);
    check("b_hs_ovf", 72'(b_ovf), 72'd0);
    check("b_hs_sum", 72'(b_sum), B_SUM);
    prod = 64'd5;
    c_v = 1'b1;
    step();
    c_v = 1'b0;
    check("c_valid", 72'(c_ov), 72'd1);
    check("c_sum", c_sum, 72'd5);
    check("c_cnt", 72'(c_cnt), 72'd1);
    check("c_rdy", 72'(c_or), 72'd0);
    step();
    check("c_hs_valid", 72'(c_ov), 72'd0);
    check("c_hs_cnt", 72'(c_cnt), 72'd0);
    prod = -64'sd2;
    c_v = 1'b1;
    step();
    c_v = 1'b0;
    check("c_sum2", c_sum, sx(-64'sd2));
    step();
    check("sb_empty", 72'(sb.size()), 72'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/product_accumulator.md
Name: product_accumulator

Overview:
- Downstream consumer of the team's 64-bit boothMult product register.
- Sums a fixed-length group of LEN signed products (dot-product reduction) into a wide accumulator.
- Delivers each group sum on a valid/ready output handshake; stalls input while a finished sum is unacknowledged.
- i_valid is produced at integration by delaying the multiplier's enable to match its 2-cycle latency.

Parameters:
- P_W, 64: signed product input width.
- ACC_W, 72: accumulator/sum width; must be >= P_W.
- LEN, 8: products per group; must be >= 1.
- CNT_W, $clog2(LEN+1): width of the count output.

Ports:
- i_clk  in  1  clock; all state changes on rising edge.
- i_rst  in  1  synchronous active-high reset.
- i_valid  in  1  i_product valid this cycle.
- i_product  in  P_W  signed two's-complement product.
- o_ready  out  1  block can accept a product this cycle.
- i_clear  in  1  synchronous abort of the current group.
- o_valid  out  1  o_sum holds a completed group sum.
- i_ready  in  1  downstream accepts o_sum.
- o_sum  out  ACC_W  signed group sum.
- o_count  out  CNT_W  products accepted in the current group.
- o_overflow  out  1  sticky per-group saturation flag; constant 0 without SAT_EN.

Behaviour:
- Reset: state ACC, accumulator 0, o_count 0, o_sum 0, o_valid 0, o_overflow 0. o_ready is 1 in the first cycle after reset.
- Priority per cycle: i_rst > i_clear > output handshake > input accept.
- States: ACC and DONE. o_ready = (state == ACC) && !i_clear, combinational from state.
- Accept: i_valid && o_ready.
  - acc <= acc + sign_extend(i_product) to ACC_W.
  - o_count <= o_count + 1.
  - i_product is ignored when not accepted.
- Group end: an accept while o_count == LEN-1:
  - o_sum <= acc + sign_extend(i_product); o_valid <= 1; state -> DONE.
  - acc <= 0; o_count <= LEN.
  - Latency is 1 cycle from the final accept edge to o_valid high.
- DONE:
  - o_ready = 0; o_sum, o_valid and o_overflow are held stable while i_ready = 0.
  - On o_valid && i_ready: o_valid <= 0, o_count <= 0, o_overflow <= 0, state -> ACC.
  - o_sum keeps its last value after the handshake.
  - At best this costs one bubble cycle per group.
- o_sum changes only at group end or reset.
- i_clear in any state: acc <= 0, o_count <= 0, o_valid <= 0, o_overflow <= 0, state -> ACC.
  - A product presented in the same cycle is dropped.
  - o_sum is not cleared.
- LEN = 1: every accept completes a group.
- Arithmetic: two's complement, wraps modulo 2^ACC_W unless SAT_EN is defined.

Optional Feature:
- Macro: PRODUCT_ACCUMULATOR_SAT_EN.
- Defined:
  - Each add detects signed overflow (operands same sign, result sign differs).
  - On overflow the result clamps to 2^(ACC_W-1)-1 (positive) or -2^(ACC_W-1) (negative).
  - o_overflow is set and stays set until the handshake, i_clear or i_rst.
  - Later adds start from the clamped value.
- Undefined: wraparound arithmetic; o_overflow tied 0; no saturation logic.

Test Plan:
1. LEN=4, after reset, i_ready=1, products 1,2,3,4 on consecutive cycles -> o_valid high 1 cycle after the 4th accept, o_sum=10, o_count=4; next cycle o_valid=0, o_ready=1, o_count=0.
2. LEN=4, products -5,3,0,-1 -> o_sum = -3 (72'hFF..FFD), o_overflow=0.
3. Backpressure: group of 7,7,7,7 done, i_ready=0 for 5 cycles while i_valid=1 -> o_sum=28 and o_valid=1 held, o_ready=0, no products counted. Raise i_ready -> handshake, then the next group sums from 0.
4. i_clear after 2 accepted products (5,5), then products 10,10,10,10 -> o_sum=40; the product coincident with i_clear is not counted.
5. ACC_W=64, LEN=4, products 2^62 x4 -> with PRODUCT_ACCUMULATOR_SAT_EN: o_sum=64'h7FFF_FFFF_FFFF_FFFF, o_overflow=1, cleared after the handshake. Without it: o_sum=0, o_overflow=0.
6. i_rst asserted in DONE with i_ready=0 -> next cycle o_valid=0, o_sum=0, o_count=0, o_ready=1; a following group 1,1,1,1 gives o_sum=4.
